// File: rtl/riscv_boot_ctrl.sv
// Boot/run sequencer: streams words into data memory with the CPU held in reset,
// then runs the CPU until its PC parks in a halt loop or the cycle budget expires.
module riscv_boot_ctrl #(
  parameter logic [31:0] BASE_ADR    = 32'h0000_0000,
  parameter int unsigned HALT_CYCLES = 4,
  parameter logic [31:0] MAX_CYCLES  = 32'd100_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  load_count,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  input  logic [31:0] peek_adr,
  input  logic [31:0] PC,
  output logic        cpu_reset,
  output logic        Ext_MemWrite,
  output logic [31:0] Ext_WriteData,
  output logic [31:0] Ext_DataAdr,
  output logic        busy,
  output logic        done,
  output logic        timeout,
  output logic [31:0] run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_LAST,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [31:0] STABLE_LAST = 32'(HALT_CYCLES - 2);

  state_t      state_q;
  logic [7:0]  idx_q;
  logic [7:0]  cnt_q;
  logic        wr_q;
  logic [31:0] wdata_q;
  logic [31:0] wadr_q;
  logic [31:0] run_q;
  logic        timeout_q;
  logic [31:0] prev_pc_q;
  logic [31:0] stable_q;

  logic halt_hit;
  logic budget_hit;

  assign halt_hit   = (PC == prev_pc_q) && (stable_q == STABLE_LAST);
  assign budget_hit = (run_q == MAX_CYCLES - 32'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 8'd0;
      cnt_q     <= 8'd0;
      wr_q      <= 1'b0;
      wdata_q   <= 32'd0;
      wadr_q    <= 32'd0;
      run_q     <= 32'd0;
      timeout_q <= 1'b0;
      prev_pc_q <= 32'd0;
      stable_q  <= 32'd0;
    end else begin
      wr_q <= 1'b0;
      case (state_q)
        S_IDLE, S_HALT: begin
          if (start) begin
            run_q     <= 32'd0;
            timeout_q <= 1'b0;
            idx_q     <= 8'd0;
            cnt_q     <= load_count;
            if (load_count != 8'd0) begin
              state_q <= S_LOAD;
            end else begin
              state_q   <= S_RUN;
              prev_pc_q <= PC;
              stable_q  <= 32'd0;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            wr_q    <= 1'b1;
            wdata_q <= in_data;
            wadr_q  <= BASE_ADR + {22'd0, idx_q, 2'b00};
            idx_q   <= idx_q + 8'd1;
            if (idx_q == cnt_q - 8'd1) state_q <= S_LAST;
          end
        end
        S_LAST: begin
          // prev_pc is seeded here so the very first RUN cycle compares against a real PC
          state_q   <= S_RUN;
          prev_pc_q <= PC;
          stable_q  <= 32'd0;
        end
        S_RUN: begin
          run_q     <= run_q + 32'd1;
          prev_pc_q <= PC;
          stable_q  <= (PC == prev_pc_q) ? stable_q + 32'd1 : 32'd0;
          if (halt_hit) begin
            state_q   <= S_HALT;
            timeout_q <= 1'b0;
          end else if (budget_hit) begin
            state_q   <= S_HALT;
            timeout_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = (state_q == S_LOAD);
  assign cpu_reset     = (state_q != S_RUN);
  assign busy          = (state_q == S_LOAD) || (state_q == S_LAST) || (state_q == S_RUN);
  assign done          = (state_q == S_HALT);
  assign timeout       = timeout_q;
  assign run_cycles    = run_q;
  assign Ext_MemWrite  = wr_q;
  assign Ext_WriteData = wdata_q;
  // Host peek path owns the address bus whenever no load is in flight
  assign Ext_DataAdr   = ((state_q == S_LOAD) || (state_q == S_LAST)) ? wadr_q : peek_adr;

endmodule

// File: tb/tb_riscv_boot_ctrl.sv
// Scoreboard bench for riscv_boot_ctrl: load writes are queued on acceptance and
// popped when the write strobe appears; run/halt/timeout results are checked directly.
module tb_riscv_boot_ctrl;

  localparam logic [31:0] BASE = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  load_count = 8'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'd0;
  logic        in_ready;
  logic [31:0] peek_adr = 32'd0;
  logic [31:0] PC = 32'hFFFF_0000;
  logic        cpu_reset;
  logic        Ext_MemWrite;
  logic [31:0] Ext_WriteData;
  logic [31:0] Ext_DataAdr;
  logic        busy;
  logic        done;
  logic        timeout;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;
  int strobes = 0;
  logic [63:0] sb[$];
  logic [63:0] e;

  riscv_boot_ctrl #(
    .BASE_ADR   (BASE),
    .HALT_CYCLES(4),
    .MAX_CYCLES (32'd10)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .load_count   (load_count),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .peek_adr     (peek_adr),
    .PC           (PC),
    .cpu_reset    (cpu_reset),
    .Ext_MemWrite (Ext_MemWrite),
    .Ext_WriteData(Ext_WriteData),
    .Ext_DataAdr  (Ext_DataAdr),
    .busy         (busy),
    .done         (done),
    .timeout      (timeout),
    .run_cycles   (run_cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset && Ext_MemWrite === 1'b1) begin
      strobes++;
      if (sb.size() == 0) begin
        check("spurious_wr", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("wr_adr", Ext_DataAdr, e[63:32]);
        check("wr_data", Ext_WriteData, e[31:0]);
      end
    end
  end

  // Call at a negedge; returns at the negedge of the first post-start cycle.
  task automatic do_start(input logic [7:0] lc);
    start = 1'b1;
    load_count = lc;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Call at a negedge in LOAD; returns at the negedge of the first RUN cycle.
  task automatic load_words(input int n, input bit toggle);
    int sent = 0;
    int cyc = 0;
    while (sent < n && cyc < 60) begin
      in_valid = toggle ? (cyc % 2 == 0) : 1'b1;
      in_data = $urandom;
      if (in_valid && in_ready) begin
        sb.push_back({BASE + 32'(sent * 4), in_data});
        sent++;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("load_beats", 32'(sent), 32'(n));
    check("last_in_ready", in_ready, 32'd0);
    check("last_cpu_reset", cpu_reset, 32'd1);
    check("last_busy", busy, 32'd1);
    @(negedge clk);
    check("run_cpu_reset", cpu_reset, 32'd0);
    check("run_busy", busy, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    peek_adr = 32'h0000_1234;
    #12;
    check("rst_cpu_reset", cpu_reset, 32'd1);
    check("rst_in_ready", in_ready, 32'd0);
    check("rst_memwrite", Ext_MemWrite, 32'd0);
    check("rst_wdata", Ext_WriteData, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_done", done, 32'd0);
    check("rst_timeout", timeout, 32'd0);
    check("rst_run_cycles", run_cycles, 32'd0);
    check("rst_peek", Ext_DataAdr, 32'h0000_1234);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_cpu_reset", cpu_reset, 32'd1);

    // Continuous-valid load of three words, then halt loop 0,4,8,8,8,8
    do_start(8'd3);
    check("load_in_ready", in_ready, 32'd1);
    load_words(3, 1'b0);
    begin
      logic [31:0] pcs [6];
      pcs = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
      for (int i = 0; i < 6; i++) begin
        check("halt_not_yet", done, 32'd0);
        PC = pcs[i];
        @(negedge clk);
      end
    end
    check("halt_done", done, 32'd1);
    check("halt_timeout", timeout, 32'd0);
    check("halt_run_cycles", run_cycles, 32'd6);
    check("halt_cpu_reset", cpu_reset, 32'd1);
    check("halt_busy", busy, 32'd0);

    // Toggling-valid load, then incrementing PC until the 10-cycle budget expires
    do_start(8'd3);
    check("restart_done", done, 32'd0);
    check("restart_run_cycles", run_cycles, 32'd0);
    load_words(3, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("budget_not_yet", done, 32'd0);
      PC = 32'h100 + 32'(i * 4);
      @(negedge clk);
    end
    check("budget_done", done, 32'd1);
    check("budget_timeout", timeout, 32'd1);
    check("budget_run_cycles", run_cycles, 32'd10);
    peek_adr = 32'h0000_0008;
    #1;
    check("halt_peek", Ext_DataAdr, 32'h0000_0008);
    check("halt_memwrite", Ext_MemWrite, 32'd0);

    // Start with load_count=0 from HALT goes straight to RUN; start in RUN is ignored
    @(negedge clk);
    PC = 32'h1;
    do_start(8'd0);
    check("direct_cpu_reset", cpu_reset, 32'd0);
    check("direct_done", done, 32'd0);
    check("direct_timeout", timeout, 32'd0);
    check("direct_run_cycles", run_cycles, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("direct_not_yet", done, 32'd0);
      check("run_no_ready", in_ready, 32'd0);
      PC = 32'h40;
      start = (i == 1);
      load_count = 8'd5;
      @(negedge clk);
    end
    start = 1'b0;
    check("direct_halt_done", done, 32'd1);
    check("direct_halt_cycles", run_cycles, 32'd4);

    // Reset mid-LOAD after 2 of 5 words; a start pulse inside LOAD is ignored
    do_start(8'd5);
    check("load5_done", done, 32'd0);
    for (int i = 0; i < 2; i++) begin
      check("load5_ready", in_ready, 32'd1);
      in_valid = 1'b1;
      in_data = $urandom;
      sb.push_back({BASE + 32'(i * 4), in_data});
      start = (i == 1);
      load_count = 8'd0;
      @(negedge clk);
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("load_start_ignored", in_ready, 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("abort_memwrite", Ext_MemWrite, 32'd0);
    check("abort_cpu_reset", cpu_reset, 32'd1);
    check("abort_busy", busy, 32'd0);
    check("abort_in_ready", in_ready, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_idle_memwrite", Ext_MemWrite, 32'd0);
    do_start(8'd5);
    load_words(5, 1'b0);
    @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    check("strobe_total", 32'(strobes), 32'd13);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
